// File: rtl/btb_pkg.sv
// Shared types and widths for the BTB update controller.
// The BTB geometry (S_INDEX) is fixed here because the update payload struct depends on it.
package btb_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned S_INDEX  = 3;
  localparam int unsigned NUM_SETS = 2 ** S_INDEX;
  localparam int unsigned IDX_LSB  = 2;
  localparam int unsigned TAG_W    = PC_W - S_INDEX - IDX_LSB;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [S_INDEX-1:0] index;
    logic [PC_W-1:0]    target;
  } btb_upd_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Split a branch PC into BTB index/tag; pc[1:0] is dropped.
  function automatic btb_upd_t make_upd(input logic [PC_W-1:0] pc,
                                        input logic [PC_W-1:0] target);
    btb_upd_t u;
    u.tag    = pc[PC_W-1 -: TAG_W];
    u.index  = pc[IDX_LSB +: S_INDEX];
    u.target = target;
    return u;
  endfunction

endpackage

// File: rtl/upd_fifo.sv
// Synchronous FIFO of BTB updates with occupancy count and synchronous clear.
// Storage is not reset; only pointers and count are.
module upd_fifo
  import btb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  btb_upd_t         i_data,
  input  logic             i_pop,
  output btb_upd_t         o_head,
  output logic [CNT_W-1:0] o_count
);

  btb_upd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !i_clear && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !i_clear && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences all BTB writes: init/flush invalidate walk, round-robin capture of
// resolved-branch updates, and FIFO drain that yields to fetch lookups with a starvation cap.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*PC_W-1:0] req_pc,
  input  logic [NUM_REQ*PC_W-1:0] req_target,
  input  logic                    flush,
  input  logic                    fetch_lookup,
  output logic                    btb_load,
  output logic [S_INDEX-1:0]      btb_windex,
  output logic [TAG_W-1:0]        btb_wtag,
  output logic [PC_W-1:0]         btb_wtarget,
  output logic                    btb_wvalid,
  output logic                    busy
);

  localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [S_INDEX-1:0] r_walk;
  logic [S_INDEX-1:0] w_walk_nxt;
  logic [STV_W-1:0]   r_starve;
  logic [STV_W-1:0]   w_starve_nxt;
  logic [RR_W-1:0]    r_rr;
  logic [RR_W-1:0]    w_rr_nxt;

  logic [PC_W-1:0]    w_pc_arr  [NUM_REQ];
  logic [PC_W-1:0]    w_tgt_arr [NUM_REQ];
  logic               w_arb_en;
  logic               w_gnt_found;
  logic [RR_W-1:0]    w_gnt_idx;
  logic [RR_W-1:0]    w_cand;
  logic [NUM_REQ-1:0] w_gnt_vec;

  logic               w_push;
  logic               w_pop;
  logic               w_clear;
  btb_upd_t           w_push_data;
  btb_upd_t           w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_nonempty;
  logic               w_drain;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_pc_arr[g]  = req_pc[g*PC_W +: PC_W];
    assign w_tgt_arr[g] = req_target[g*PC_W +: PC_W];
  end

  assign w_full     = (w_count == CNT_W'(DEPTH));
  assign w_nonempty = (w_count != '0);
  // Readiness looks at the pre-dequeue count: a full FIFO takes nothing even while draining.
  assign w_arb_en   = rst && (r_state == RUN) && !flush && !w_full;
  assign w_drain    = w_nonempty &&
                      (!fetch_lookup || w_full || (r_starve == STV_W'(STARVE_LIMIT)));

  // Round-robin search starting at r_rr; first valid requester wins.
  always_comb begin
    w_gnt_vec   = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = RR_W'((32'(r_rr) + i) % NUM_REQ);
      if (w_arb_en && !w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
    if (w_gnt_found) w_gnt_vec[w_gnt_idx] = 1'b1;
  end

  assign req_ready   = w_gnt_vec;
  assign w_push_data = make_upd(w_pc_arr[w_gnt_idx], w_tgt_arr[w_gnt_idx]);
  assign busy        = !rst || (r_state == INIT);

  // Next-state and BTB write port drive.
  always_comb begin
    w_state_nxt  = r_state;
    w_walk_nxt   = r_walk;
    w_starve_nxt = r_starve;
    w_rr_nxt     = r_rr;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    btb_load     = 1'b0;
    btb_windex   = '0;
    btb_wtag     = '0;
    btb_wtarget  = '0;
    btb_wvalid   = 1'b0;

    case (r_state)
      INIT: begin
        btb_load   = 1'b1;
        btb_windex = r_walk;
        if (flush) begin
          w_walk_nxt = '0;
        end else if (r_walk == S_INDEX'(NUM_SETS - 1)) begin
          w_walk_nxt  = '0;
          w_state_nxt = RUN;
        end else begin
          w_walk_nxt = r_walk + S_INDEX'(1);
        end
      end
      RUN: begin
        if (flush) begin
          w_clear      = 1'b1;
          w_starve_nxt = '0;
          w_walk_nxt   = '0;
          w_state_nxt  = INIT;
        end else begin
          if (w_gnt_found) begin
            w_push   = 1'b1;
            w_rr_nxt = RR_W'((32'(w_gnt_idx) + 1) % NUM_REQ);
          end
          if (w_drain) begin
            w_pop        = 1'b1;
            w_starve_nxt = '0;
            btb_load     = 1'b1;
            btb_wvalid   = 1'b1;
            btb_windex   = w_head.index;
            btb_wtag     = w_head.tag;
            btb_wtarget  = w_head.target;
          end else if (w_nonempty) begin
            if (r_starve != STV_W'(STARVE_LIMIT)) w_starve_nxt = r_starve + STV_W'(1);
          end else begin
            w_starve_nxt = '0;
          end
        end
      end
    endcase

    // Write port stays quiet while reset is asserted.
    if (!rst) begin
      btb_load    = 1'b0;
      btb_windex  = '0;
      btb_wtag    = '0;
      btb_wtarget = '0;
      btb_wvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= INIT;
      r_walk   <= '0;
      r_starve <= '0;
      r_rr     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_walk   <= w_walk_nxt;
      r_starve <= w_starve_nxt;
      r_rr     <= w_rr_nxt;
    end
  end

  upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus queues expected BTB writes,
// a negedge monitor pops and compares every btb_load.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  typedef struct packed {
    logic [2:0]  idx;
    logic [26:0] tag;
    logic [31:0] tgt;
    logic        vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_pc;
  logic [63:0] req_target;
  logic        flush;
  logic        fetch_lookup;
  logic        btb_load;
  logic [2:0]  btb_windex;
  logic [26:0] btb_wtag;
  logic [31:0] btb_wtarget;
  logic        btb_wvalid;
  logic        busy;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Test 2 vectors: requester 0 (A) and 1 (B); grants alternate 0,1,0,1.
  localparam logic [31:0] A_PC  [4] = '{32'h0000_0044, 32'hDEAD_0001, 32'hFFFF_FFFC, 32'hDEAD_0003};
  localparam logic [31:0] A_TGT [4] = '{32'h1000_0000, 32'hDEAD_1001, 32'h0000_0003, 32'hDEAD_1003};
  localparam logic [31:0] B_PC  [4] = '{32'hBEEF_0000, 32'h0000_1008, 32'hBEEF_0002, 32'h0000_0047};
  localparam logic [31:0] B_TGT [4] = '{32'hBEEF_1000, 32'h2000_0000, 32'hBEEF_1002, 32'h3000_0004};
  localparam logic [2:0]  E_IDX [4] = '{3'd1, 3'd2, 3'd7, 3'd1};
  localparam logic [26:0] E_TAG [4] = '{27'h2, 27'h80, 27'h7FF_FFFF, 27'h2};
  localparam logic [31:0] E_TGT [4] = '{32'h1000_0000, 32'h2000_0000, 32'h0000_0003, 32'h3000_0004};

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pc       (req_pc),
    .req_target   (req_target),
    .flush        (flush),
    .fetch_lookup (fetch_lookup),
    .btb_load     (btb_load),
    .btb_windex   (btb_windex),
    .btb_wtag     (btb_wtag),
    .btb_wtarget  (btb_wtarget),
    .btb_wvalid   (btb_wvalid),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] idx, input logic [26:0] tag,
                          input logic [31:0] tgt, input logic vld);
    exp_t e;
    e.idx = idx;
    e.tag = tag;
    e.tgt = tgt;
    e.vld = vld;
    sb_q.push_back(e);
  endtask

  task automatic push_walk(input int first, input int last);
    for (int i = first; i <= last; i++) push_exp(3'(i), 27'h0, 32'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write seen on the BTB port must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && btb_load === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got idx=%0d tag=0x%0h tgt=0x%0h vld=%0b, expected no write",
                 btb_windex, btb_wtag, btb_wtarget, btb_wvalid);
      end else begin
        e = sb_q.pop_front();
        chk("wr_index",  64'(btb_windex),  64'(e.idx));
        chk("wr_tag",    64'(btb_wtag),    64'(e.tag));
        chk("wr_target", 64'(btb_wtarget), 64'(e.tgt));
        chk("wr_valid",  64'(btb_wvalid),  64'(e.vld));
      end
    end
  end

  initial begin
    rst          = 1'b0;
    req_valid    = 2'b11;
    req_pc       = '0;
    req_target   = '0;
    flush        = 1'b0;
    fetch_lookup = 1'b0;

    // Reset state
    #2;
    chk("rst_load",  64'(btb_load),  64'd0);
    chk("rst_busy",  64'(busy),      64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_index", 64'(btb_windex), 64'd0);

    // Init walk after release
    step();
    rst = 1'b1;
    push_walk(0, 7);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("init_load",  64'(btb_load),   64'd1);
      chk("init_index", 64'(btb_windex), 64'(i));
      chk("init_busy",  64'(busy),       64'd1);
      chk("init_ready", 64'(req_ready),  64'd0);
      step();
    end

    // Alternating round-robin, no fetch pressure
    for (int j = 0; j < 4; j++) begin
      req_valid  = 2'b11;
      req_pc     = {B_PC[j], A_PC[j]};
      req_target = {B_TGT[j], A_TGT[j]};
      #2;
      if (j == 0) chk("run_busy", 64'(busy), 64'd0);
      chk("rr_ready", 64'(req_ready), (j % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_load",  64'(btb_load),  (j == 0) ? 64'd0 : 64'd1);
      push_exp(E_IDX[j], E_TAG[j], E_TGT[j], 1'b1);
      step();
    end
    req_valid = 2'b00;
    #2;
    chk("rr_last_load", 64'(btb_load), 64'd1);
    step();
    #2;
    chk("rr_idle_load", 64'(btb_load), 64'd0);
    step();

    // Starvation: fetch holds the port, single update forced out on cycle 9
    fetch_lookup = 1'b1;
    req_valid    = 2'b01;
    req_pc       = {32'h0, 32'h0000_0100};
    req_target   = {32'h0, 32'hABCD_0000};
    #2;
    chk("stv_ready", 64'(req_ready), 64'd1);
    push_exp(3'd0, 27'h8, 32'hABCD_0000, 1'b1);
    step();
    req_valid = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #2;
      chk("stv_defer", 64'(btb_load), 64'd0);
      step();
    end
    #2;
    chk("stv_force", 64'(btb_load), 64'd1);
    step();
    #2;
    chk("stv_after", 64'(btb_load), 64'd0);
    step();

    // Fill to DEPTH under fetch pressure; full forces a drain, ready stays low
    req_valid  = 2'b11;
    req_pc     = {32'h0000_0208, 32'hBAD0_0000};
    req_target = {32'h0000_4000, 32'hBAD1_0000};
    #2;
    chk("fill0_ready", 64'(req_ready), 64'd2);
    push_exp(3'd2, 27'h10, 32'h0000_4000, 1'b1);
    step();
    req_pc = {32'hBAD0_0011, 32'hBAD0_0010};
    #2;
    chk("fill1_ready", 64'(req_ready), 64'd1);
    chk("fill1_load",  64'(btb_load),  64'd0);
    step();
    req_valid = 2'b10;
    req_pc    = {32'hBAD0_0021, 32'hBAD0_0020};
    #2;
    chk("fill2_ready", 64'(req_ready), 64'd2);
    chk("fill2_load",  64'(btb_load),  64'd0);
    step();
    req_pc = {32'hBAD0_0031, 32'hBAD0_0030};
    #2;
    chk("fill3_ready", 64'(req_ready), 64'd2);
    chk("fill3_load",  64'(btb_load),  64'd0);
    step();
    req_valid = 2'b11;
    #2;
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_load",  64'(btb_load),  64'd1);
    step();

    // Flush with 3 queued: no write this cycle, walk follows; second flush restarts it
    flush = 1'b1;
    #2;
    chk("flush_ready", 64'(req_ready), 64'd0);
    chk("flush_load",  64'(btb_load),  64'd0);
    push_walk(0, 3);
    push_walk(0, 7);
    step();
    flush     = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) flush = 1'b1;
      #2;
      chk("fwalk_index", 64'(btb_windex), 64'(i));
      chk("fwalk_busy",  64'(busy),       64'd1);
      step();
    end
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("rwalk_index", 64'(btb_windex), 64'(i));
      chk("rwalk_load",  64'(btb_load),   64'd1);
      step();
    end
    #2;
    chk("flush_done_busy", 64'(busy),     64'd0);
    chk("flush_done_load", 64'(btb_load), 64'd0);
    step();

    // Reset asserted mid-drain with one entry still queued
    fetch_lookup = 1'b0;
    req_valid    = 2'b01;
    req_pc       = {32'h0000_0080, 32'h0000_003C};
    req_target   = {32'h6666_0000, 32'h5555_0000};
    #2;
    chk("drain_ready", 64'(req_ready), 64'd1);
    push_exp(3'd7, 27'h1, 32'h5555_0000, 1'b1);
    step();
    req_valid = 2'b10;
    #2;
    chk("drain_ready2", 64'(req_ready), 64'd2);
    chk("drain_load",   64'(btb_load),  64'd1);
    #4;
    rst = 1'b0;
    #1;
    chk("arst_load",   64'(btb_load),    64'd0);
    chk("arst_index",  64'(btb_windex),  64'd0);
    chk("arst_tag",    64'(btb_wtag),    64'd0);
    chk("arst_target", 64'(btb_wtarget), 64'd0);
    chk("arst_valid",  64'(btb_wvalid),  64'd0);
    chk("arst_ready",  64'(req_ready),   64'd0);
    chk("arst_busy",   64'(busy),        64'd1);
    step();
    rst       = 1'b1;
    req_valid = 2'b00;
    push_walk(0, 7);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("rewalk_index", 64'(btb_windex), 64'(i));
      step();
    end
    #2;
    chk("rewalk_busy", 64'(busy),     64'd0);
    chk("rewalk_load", 64'(btb_load), 64'd0);
    step();

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
